// File: rtl/stepper_pkg.sv
// stepper_pkg: shared definitions for the stepper axis controller.
//   - PHASE_TABLE : 8-entry coil pattern table, index 0..7 (even = full-step)
//   - state_e     : controller FSM states
//   - DIR_UP / DIR_DOWN : command direction encodings
package stepper_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Element 0 is the rightmost entry; coils[3] is the MSB of each pattern.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b0010,  // 7
        4'b0110,  // 6
        4'b0100,  // 5
        4'b1100,  // 4
        4'b1000,  // 3
        4'b1001,  // 2
        4'b0001,  // 1
        4'b0011   // 0
    };

endpackage

// File: rtl/stepper_axis_ctrl_if.sv
// stepper_axis_ctrl_if: move-command handshake bundle.
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  controller idle, transfer on valid & ready
//   cmd_dir    master->slave  0 = up/forward, 1 = down/reverse
//   cmd_steps  master->slave  number of step events
//   cmd_half   master->slave  1 = half-step, 0 = full-step
interface stepper_axis_ctrl_if #(
    parameter int unsigned STEPS_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;
    logic               cmd_half;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_half,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_half,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_tick_gen.sv
// stepper_tick_gen: step-interval timer.
//   clk, rst      clock and synchronous active-high reset
//   load_i        restart timing for a new move (first interval begins now)
//   en_i          move in progress; the counter only runs while enabled
//   step_tick_o   one-cycle pulse; the step is taken on the following edge
// Optional: STEPPER_RAMP_EN selects a start period of START_DIV that shrinks by
// RAMP_DEC per step down to STEP_DIV; otherwise every interval is STEP_DIV.
module stepper_tick_gen #(
    parameter int unsigned STEP_DIV  = 250000,
    parameter int unsigned START_DIV = 1000000,
    parameter int unsigned RAMP_DEC  = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic step_tick_o
);
    localparam int unsigned MaxDiv = (START_DIV > STEP_DIV) ? START_DIV : STEP_DIV;
    localparam int unsigned TW     = $clog2(MaxDiv) + 1;
    localparam logic [TW-1:0] StepP = TW'(STEP_DIV);

    if (STEP_DIV < 2 || RAMP_DEC > START_DIV) begin : g_bad_param
        $error("stepper_tick_gen: STEP_DIV must be >= 2 and RAMP_DEC <= START_DIV");
    end

    logic [TW-1:0] cnt_q, cnt_d;

    // Counter holds cycles left before the step edge; zero means "step next edge".
    assign step_tick_o = en_i && (cnt_q == '0);

`ifdef STEPPER_RAMP_EN
    localparam logic [TW-1:0] StartP = TW'(START_DIV);

    logic [TW-1:0] period_q, period_d, period_nx;
    logic [31:0]   period_ext;

    assign period_ext = 32'(period_q);
    // Saturate at cruise speed without ever going below it.
    assign period_nx  = (period_ext >= STEP_DIV + RAMP_DEC) ? TW'(period_ext - RAMP_DEC) : StepP;

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            period_d = StartP;
            cnt_d    = StartP - 1'b1;
        end else if (step_tick_o) begin
            period_d = period_nx;
            cnt_d    = period_nx - 1'b1;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= StartP;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    always_comb begin
        cnt_d = cnt_q;
        if (load_i || step_tick_o) begin
            cnt_d = StepP - 1'b1;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/stepper_axis_ctrl.sv
// stepper_axis_ctrl: command-driven stepper phase sequencer.
//   clk, rst   clock, synchronous active-high reset
//   cmd        slave side of the move-command handshake (valid/ready/dir/steps/half)
//   stop       abort the running move (ignored while idle)
//   coils      4-wire coil pattern
//   busy       move in progress
//   done       one-cycle pulse at move end
//   position   signed absolute position in half-step units (wraps mod 2^POS_W)
// Optional: STEPPER_RAMP_EN enables the acceleration ramp in stepper_tick_gen.
module stepper_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV  = 250000,
    parameter int unsigned STEPS_W   = 16,
    parameter int unsigned POS_W     = 24,
    parameter bit          HOLD      = 1'b1,
    parameter int unsigned START_DIV = 1000000,
    parameter int unsigned RAMP_DEC  = 5000
) (
    input  logic                   clk,
    input  logic                   rst,
    stepper_axis_ctrl_if.slave     cmd,
    input  logic                   stop,
    output logic [3:0]             coils,
    output logic                   busy,
    output logic                   done,
    output logic [POS_W-1:0]       position
);
    state_e             state_q;
    logic [2:0]         idx_q;
    logic [STEPS_W-1:0] count_q;
    logic [POS_W-1:0]   pos_q;
    logic               dir_q, half_q, busy_q, done_q;
    logic [3:0]         coils_q;

    logic       step_tick, accept, run_end;
    logic [2:0] mag, idx_nx;
    logic [POS_W-1:0] pos_nx;

    assign accept        = (state_q == StIdle) && cmd.cmd_valid;
    assign cmd.cmd_ready = (state_q == StIdle);

    stepper_tick_gen #(
        .STEP_DIV  (STEP_DIV),
        .START_DIV (START_DIV),
        .RAMP_DEC  (RAMP_DEC)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .en_i        (state_q == StRun),
        .step_tick_o (step_tick)
    );

    // Full mode from an odd (half) phase moves one slot to realign to a full phase.
    assign mag    = (half_q || idx_q[0]) ? 3'd1 : 3'd2;
    assign idx_nx = (dir_q == DIR_DOWN) ? idx_q - mag : idx_q + mag;
    assign pos_nx = (dir_q == DIR_DOWN) ? pos_q - POS_W'(mag) : pos_q + POS_W'(mag);

    // A zero-step command ends on the first RUN edge; a stop on a tick edge
    // still lets that step through.
    assign run_end = stop || (step_tick ? (count_q == STEPS_W'(1)) : (count_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            count_q <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            half_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            coils_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        dir_q   <= cmd.cmd_dir;
                        half_q  <= cmd.cmd_half;
                        count_q <= cmd.cmd_steps;
                        coils_q <= PHASE_TABLE[idx_q];
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (step_tick) begin
                        idx_q   <= idx_nx;
                        pos_q   <= pos_nx;
                        coils_q <= PHASE_TABLE[idx_nx];
                        count_q <= count_q - 1'b1;
                    end
                    if (run_end) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                        if (!HOLD) begin
                            coils_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign coils    = coils_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign position = pos_q;

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
module tb_stepper_axis_ctrl;
    localparam int unsigned STEP_DIV = 4;
    localparam int unsigned STEPS_W  = 16;
    localparam int unsigned POS_W    = 24;
`ifdef STEPPER_RAMP_EN
    localparam int unsigned START_DIV = 8;
    localparam int unsigned RAMP_DEC  = 2;
`else
    localparam int unsigned START_DIV = 1000000;
    localparam int unsigned RAMP_DEC  = 5000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop = 1'b0;
    logic [3:0]       coils0, coils1;
    logic             busy0, busy1, done0, done1;
    logic [POS_W-1:0] pos0, pos1;

    stepper_axis_ctrl_if #(.STEPS_W(STEPS_W)) if0 ();
    stepper_axis_ctrl_if #(.STEPS_W(STEPS_W)) if1 ();

    assign if1.cmd_valid = if0.cmd_valid;
    assign if1.cmd_dir   = if0.cmd_dir;
    assign if1.cmd_steps = if0.cmd_steps;
    assign if1.cmd_half  = if0.cmd_half;

    stepper_axis_ctrl #(
        .STEP_DIV(STEP_DIV), .STEPS_W(STEPS_W), .POS_W(POS_W), .HOLD(1'b1),
        .START_DIV(START_DIV), .RAMP_DEC(RAMP_DEC)
    ) dut_hold (
        .clk(clk), .rst(rst), .cmd(if0.slave), .stop(stop),
        .coils(coils0), .busy(busy0), .done(done0), .position(pos0)
    );

    stepper_axis_ctrl #(
        .STEP_DIV(STEP_DIV), .STEPS_W(STEPS_W), .POS_W(POS_W), .HOLD(1'b0),
        .START_DIV(START_DIV), .RAMP_DEC(RAMP_DEC)
    ) dut_nohold (
        .clk(clk), .rst(rst), .cmd(if1.slave), .stop(stop),
        .coils(coils1), .busy(busy1), .done(done1), .position(pos1)
    );

    always #5 clk = ~clk;

    // Reference model: phase index, position and the current coil pattern.
    logic [3:0]       tbl [8] = '{4'b0011, 4'b0001, 4'b1001, 4'b1000,
                                  4'b1100, 4'b0100, 4'b0110, 4'b0010};
    int               m_idx;
    logic [POS_W-1:0] m_pos;
    logic [3:0]       m_coils;
    bit               m_busy;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit exp_done);
        chk("coils", 32'(coils0), 32'(m_coils));
        chk("position", 32'(pos0), 32'(m_pos));
        chk("busy", 32'(busy0), 32'(m_busy));
        chk("done", 32'(done0), 32'(exp_done));
        chk("cmd_ready", 32'(if0.cmd_ready), 32'(!m_busy));
        chk("coils_nohold", 32'(coils1), m_busy ? 32'(m_coils) : 32'd0);
        chk("position_nohold", 32'(pos1), 32'(m_pos));
        chk("done_nohold", 32'(done1), 32'(exp_done));
    endtask

    // Length of the n-th step interval (n starts at 1).
    function automatic int interval(input int n);
        int p;
`ifdef STEPPER_RAMP_EN
        p = int'(START_DIV);
        for (int i = 2; i <= n; i++) begin
            p = (p - int'(RAMP_DEC) < int'(STEP_DIV)) ? int'(STEP_DIV) : p - int'(RAMP_DEC);
        end
`else
        p = int'(STEP_DIV) + 0 * n;
`endif
        return p;
    endfunction

    task automatic model_step(input bit dir, input bit half);
        int mag;
        mag = (half || (m_idx % 2 == 1)) ? 1 : 2;
        if (dir) begin
            m_idx = (m_idx - mag + 8) % 8;
            m_pos = m_pos - POS_W'(mag);
        end else begin
            m_idx = (m_idx + mag) % 8;
            m_pos = m_pos + POS_W'(mag);
        end
        m_coils = tbl[m_idx];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.cmd_valid = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        m_pos = '0;
        m_coils = 4'b0000;
        m_busy = 1'b0;
        check_all(1'b0);
    endtask

    // stop_at: 0 = stop raised together with the command (idle, ignored);
    // c > 0 = stop high during the cycle before edge T+c; -1 = never.
    task automatic move(input bit dir, input int steps, input bit half, input int stop_at);
        int  k, next_ev;
        bit  fin;
        @(negedge clk);
        if0.cmd_valid = 1'b1;
        if0.cmd_dir   = dir;
        if0.cmd_steps = STEPS_W'(steps);
        if0.cmd_half  = half;
        stop = (stop_at == 0);
        @(negedge clk);
        if0.cmd_valid = 1'b0;
        m_coils = tbl[m_idx];
        m_busy = 1'b1;
        check_all(1'b0);
        k = 0;
        next_ev = interval(1);
        fin = 1'b0;
        for (int c = 1; c < 5000 && !fin; c++) begin
            stop = (c == stop_at);
            @(negedge clk);
            if (c == next_ev && k < steps) begin
                model_step(dir, half);
                k++;
                next_ev += interval(k + 1);
            end
            if (k == steps || c == stop_at) begin
                fin = 1'b1;
                m_busy = 1'b0;
            end
            check_all(fin);
        end
        stop = 1'b0;
        if (!fin) chk("move_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_all(1'b0);
    endtask

    initial begin
        if0.cmd_valid = 1'b0;
        if0.cmd_dir   = 1'b0;
        if0.cmd_steps = '0;
        if0.cmd_half  = 1'b0;
        do_reset();

        // Full up 3 from idx0: ends on 0110 at position 6.
        move(1'b0, 3, 1'b0, -1);
        chk("full3_coils", 32'(coils0), 32'h6);
        chk("full3_pos", 32'(pos0), 32'd6);

        // Half down 2 from idx0: 0010 then 0110, position -2.
        do_reset();
        move(1'b1, 2, 1'b1, -1);
        chk("half_down_coils", 32'(coils0), 32'h6);
        chk("half_down_pos", 32'(pos0), 32'hFF_FFFE);

        // Half up 1 then full up 1 realigns with a single-slot step.
        do_reset();
        move(1'b0, 1, 1'b1, -1);
        chk("align_half_coils", 32'(coils0), 32'h1);
        move(1'b0, 1, 1'b0, -1);
        chk("align_full_coils", 32'(coils0), 32'h9);
        chk("align_pos", 32'(pos0), 32'd2);

        // Full up 10 with stop before edge T+6: one step, then done.
        do_reset();
        move(1'b0, 10, 1'b0, 6);
        chk("stop_coils", 32'(coils0), 32'h9);
        chk("stop_pos", 32'(pos0), 32'd2);
        chk("stop_coils_nohold", 32'(coils1), 32'h0);

        // Stop coinciding with a step edge, zero-step command, ramp-length move.
        move(1'b0, 5, 1'b1, 4);
        move(1'b1, 0, 1'b0, -1);
        move(1'b0, 4, 1'b0, -1);

        // Randomized moves against the model.
        for (int n = 0; n < 20; n++) begin
            int sa;
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            move(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), sa);
        end

        // Reset mid-move: aborts with no done pulse.
        @(negedge clk);
        if0.cmd_valid = 1'b1;
        if0.cmd_dir   = 1'b0;
        if0.cmd_steps = STEPS_W'(9);
        if0.cmd_half  = 1'b0;
        @(negedge clk);
        if0.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
